// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared FSM state encoding and abort data pattern
//   arbState_t  - IDLE / BUSY_I / BUSY_D, 2-bit encoded
//   ABORT_DATA  - read data returned when a transaction is aborted by the watchdog
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/unified_mem_arbiter_txn_watchdog.sv
// txn_watchdog: counts busy cycles of one memory transaction and flags a hang
//   Clk, Reset  - clock, asynchronous active-high reset
//   Enable      - a transaction is in flight (counter runs)
//   Clear       - transaction completed this cycle (counter restarts)
//   Expired     - this is the TIMEOUT-th busy cycle without completion
module txn_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    input  logic Clear,
    output logic Expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (!Enable || Clear || Expired)
            count <= '0;
        else
            count <= count + 8'd1;
    end

    assign Expired = Enable && (count == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port variable-latency memory between fetch (I) and data (D) ports
//   Clk, Reset                         - clock, asynchronous active-high reset
//   IReq/IAddr -> IRdata/IReady        - fetch read port, IStall = IReq & ~IReady
//   DRead/DWrite/DAddr/DWdata
//              -> DRdata/DReady        - data port, DStall = (DRead|DWrite) & ~DReady
//   MemReq/MemWe/MemAddr/MemWdata,
//   MemRdata/MemAck                    - memory request/acknowledge handshake
//   ErrorFlag                          - sticky, set when the watchdog aborts a transaction
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRdata,
    output logic        IReady,
    input  logic        DRead,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DReady,
    output logic        IStall,
    output logic        DStall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck,
    output logic        ErrorFlag
);

    localparam logic [2:0] MAX_STREAK = 3'(MAX_DSTREAK);

    arbState_t  state;
    logic [2:0] streak;
    logic       iPend;
    logic       dPend;
    logic       dWins;
    logic       expired;

    // A port completing this cycle still shows its request; masking it stops a re-grant.
    assign iPend  = IReq & ~IReady;
    assign dPend  = (DRead | DWrite) & ~DReady;
    // Data wins unless fetch has waited through MAX_DSTREAK data grants.
    assign dWins  = (streak < MAX_STREAK) || !iPend;
    assign MemReq = (state != IDLE);
    assign IStall = IReq & ~IReady;
    assign DStall = (DRead | DWrite) & ~DReady;

    txn_watchdog #(.TIMEOUT(TIMEOUT)) watchdog (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (MemReq),
        .Clear  (MemAck),
        .Expired(expired)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            streak    <= '0;
            MemWe     <= 1'b0;
            MemAddr   <= '0;
            MemWdata  <= '0;
            IRdata    <= '0;
            DRdata    <= '0;
            IReady    <= 1'b0;
            DReady    <= 1'b0;
            ErrorFlag <= 1'b0;
        end else begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (dPend && dWins) begin
                        state    <= BUSY_D;
                        MemAddr  <= DAddr;
                        MemWdata <= DWdata;
                        MemWe    <= DWrite;
                        streak   <= IReq ? streak + 3'd1 : 3'd0;
                    end else if (iPend) begin
                        state   <= BUSY_I;
                        MemAddr <= IAddr;
                        MemWe   <= 1'b0;
                        streak  <= '0;
                    end
                end
                default: begin
                    // An ack on the expiry cycle still counts as a normal completion.
                    if (MemAck || expired) begin
                        state <= IDLE;
                        if (!MemAck)
                            ErrorFlag <= 1'b1;
                        if (state == BUSY_I) begin
                            IReady <= 1'b1;
                            IRdata <= MemAck ? MemRdata : ABORT_DATA;
                        end else begin
                            DReady <= 1'b1;
                            DRdata <= MemAck ? (MemWe ? 32'd0 : MemRdata) : ABORT_DATA;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        IReq = 1'b0;
    logic [31:0] IAddr = '0;
    logic [31:0] IRdata;
    logic        IReady;
    logic        DRead = 1'b0;
    logic        DWrite = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWdata = '0;
    logic [31:0] DRdata;
    logic        DReady;
    logic        IStall;
    logic        DStall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata = '0;
    logic        MemAck = 1'b0;
    logic        ErrorFlag;

    int checks = 0;
    int errors = 0;

    // memory model: acks after memLat wait cycles inside a busy interval
    logic [31:0] mem [0:255];
    int          memLat = 0;
    logic        memOn = 1'b1;
    int          waitCnt = 0;

    unified_mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IRdata   (IRdata),
        .IReady   (IReady),
        .DRead    (DRead),
        .DWrite   (DWrite),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DRdata   (DRdata),
        .DReady   (DReady),
        .IStall   (IStall),
        .DStall   (DStall),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .MemAck   (MemAck),
        .ErrorFlag(ErrorFlag)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (MemReq && memOn) begin
            if (waitCnt == memLat) begin
                MemAck   = 1'b1;
                MemRdata = MemWe ? 32'd0 : mem[MemAddr[9:2]];
                if (MemWe)
                    mem[MemAddr[9:2]] = MemWdata;
                waitCnt = 0;
            end else begin
                MemAck  = 1'b0;
                waitCnt = waitCnt + 1;
            end
        end else begin
            MemAck  = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call right after a falling edge; returns read data and the number of stalled cycles.
    task automatic dTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stalls);
        DRead  = ~we;
        DWrite = we;
        DAddr  = addr;
        DWdata = wdata;
        stalls = 0;
        rdata  = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (DReady) begin
                rdata = DRdata;
                break;
            end
            if (DStall)
                stalls++;
            @(negedge Clk);
        end
        DRead  = 1'b0;
        DWrite = 1'b0;
    endtask

    task automatic iTxn(input logic [31:0] addr, output logic [31:0] rdata, output int stalls);
        IReq   = 1'b1;
        IAddr  = addr;
        stalls = 0;
        rdata  = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (IReady) begin
                rdata = IRdata;
                break;
            end
            if (IStall)
                stalls++;
            @(negedge Clk);
        end
        IReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL globalTimeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          st;
        logic [9:0]  seq;
        int          grants;
        logic        prevReq;
        logic        sawReady;

        for (int i = 0; i < 256; i++)
            mem[i] = 32'd0;
        mem[8'h10] = 32'h20080005;  // 0x40
        mem[8'h11] = 32'h11112222;  // 0x44

        // reset state
        @(negedge Clk);
        check("rstMemReq", {31'd0, MemReq}, 32'd0);
        check("rstMemAddr", MemAddr, 32'd0);
        check("rstReady", {30'd0, IReady, DReady}, 32'd0);
        check("rstRdata", IRdata | DRdata, 32'd0);
        check("rstError", {31'd0, ErrorFlag}, 32'd0);
        Reset = 1'b0;

        // zero-wait fetch
        @(negedge Clk);
        IReq  = 1'b1;
        IAddr = 32'h40;
        #1 check("t1IStallGrant", {31'd0, IStall}, 32'd1);
        @(negedge Clk);
        check("t1MemReq", {31'd0, MemReq}, 32'd1);
        check("t1MemAddr", MemAddr, 32'h40);
        check("t1MemWe", {31'd0, MemWe}, 32'd0);
        @(negedge Clk);
        #1;
        check("t1IReady", {31'd0, IReady}, 32'd1);
        check("t1IRdata", IRdata, 32'h20080005);
        check("t1IStallDone", {31'd0, IStall}, 32'd0);
        check("t1MemReqIdle", {31'd0, MemReq}, 32'd0);
        IReq = 1'b0;
        @(negedge Clk);
        check("t1IReadyPulse", {31'd0, IReady}, 32'd0);
        check("t1IRdataHold", IRdata, 32'h20080005);

        // simultaneous I and D write: D first
        IReq   = 1'b1;
        IAddr  = 32'h44;
        DWrite = 1'b1;
        DAddr  = 32'h100;
        DWdata = 32'hABCD;
        @(negedge Clk);
        check("t2MemWe", {31'd0, MemWe}, 32'd1);
        check("t2MemAddr", MemAddr, 32'h100);
        check("t2MemWdata", MemWdata, 32'hABCD);
        @(negedge Clk);
        check("t2DReady", {31'd0, DReady}, 32'd1);
        check("t2DRdataWrite", DRdata, 32'd0);
        check("t2IStillStalled", {31'd0, IStall}, 32'd1);
        DWrite = 1'b0;
        @(negedge Clk);
        check("t2IGrantAddr", MemAddr, 32'h44);
        check("t2IGrantWe", {31'd0, MemWe}, 32'd0);
        @(negedge Clk);
        check("t2IReady", {31'd0, IReady}, 32'd1);
        check("t2IRdata", IRdata, 32'h11112222);
        IReq = 1'b0;
        @(negedge Clk);
        dTxn(1'b0, 32'h100, 32'd0, rd, st);
        check("t2Readback", rd, 32'hABCD);
        check("t2ReadStalls", st, 2);

        // streak: fetch withdraws only during DReady cycles, data reads back-to-back
        @(negedge Clk);
        seq     = '0;
        grants  = 0;
        prevReq = 1'b0;
        IAddr   = 32'h1000;
        DAddr   = 32'h2000;
        DRead   = 1'b1;
        IReq    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (MemReq && !prevReq) begin
                seq = {seq[8:0], MemAddr == 32'h2000};
                grants++;
            end
            prevReq = MemReq;
            IReq = ~DReady;
            if (grants == 10 && IReady) begin
                IReq  = 1'b0;
                DRead = 1'b0;
                break;
            end
        end
        check("t3Grants", grants, 10);
        check("t3Order", {22'd0, seq}, {22'd0, 10'b1111011110});

        // watchdog timeout on a data read
        @(negedge Clk);
        memOn = 1'b0;
        dTxn(1'b0, 32'h300, 32'd0, rd, st);
        check("t4BusyCycles", st, 9);
        check("t4AbortData", rd, 32'hDEADBEEF);
        check("t4ErrorFlag", {31'd0, ErrorFlag}, 32'd1);
        memOn = 1'b1;
        @(negedge Clk);
        iTxn(32'h40, rd, st);
        check("t4NextIData", rd, 32'h20080005);
        check("t4NextIStalls", st, 2);
        check("t4ErrorSticky", {31'd0, ErrorFlag}, 32'd1);

        // write then read 0x8 with two-cycle memory
        memLat = 1;
        @(negedge Clk);
        dTxn(1'b1, 32'h8, 32'hCAFEF00D, rd, st);
        check("t6WriteStalls", st, 3);
        @(negedge Clk);
        dTxn(1'b0, 32'h8, 32'd0, rd, st);
        check("t6ReadData", rd, 32'hCAFEF00D);
        check("t6ReadStalls", st, 3);

        // reset in the middle of BUSY_D with three-cycle memory
        memLat = 2;
        @(negedge Clk);
        DRead = 1'b1;
        DAddr = 32'h100;
        @(negedge Clk);
        check("t5BusyBeforeReset", {31'd0, MemReq}, 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("t5MemReqAsync", {31'd0, MemReq}, 32'd0);
        check("t5MemAddrAsync", MemAddr, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        DRead = 1'b0;
        check("t5ErrorCleared", {31'd0, ErrorFlag}, 32'd0);
        sawReady = DReady;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            sawReady |= DReady;
        end
        check("t5NoDReady", {31'd0, sawReady}, 32'd0);
        iTxn(32'h40, rd, st);
        check("t5IData", rd, 32'h20080005);
        check("t5IStalls", st, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
